// File: rtl/snes_pkg.sv
// rtl/snes_pkg.sv - shared SNES cartridge definitions: BSRAM arbiter state type and address width
package snes_pkg;

   localparam int BSRAM_AW = 20;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_HWR  = 2'd1,
      ARB_HRD  = 2'd2,
      ARB_HACK = 2'd3
   } bsram_arb_state_t;

endpackage

// File: rtl/bsram_host_arb.sv
// rtl/bsram_host_arb.sv - BSRAM port arbiter: mapper pass-through with host save/load slotted into idle cycles
// Optional mapper-write dirty flag under macro BSRAM_DIRTY_EN.
module bsram_host_arb
   import snes_pkg::*;
#(
   parameter int AW      = BSRAM_AW,
   parameter int MEM_LAT = 1
) (
   input  logic          mclk,
   input  logic          rst_n,
   input  logic [AW-1:0] map_addr,
   input  logic [7:0]    map_d,
   input  logic          map_ce_n,
   input  logic          map_oe_n,
   input  logic          map_we_n,
   output logic [7:0]    map_q,
   input  logic [AW-1:0] ram_mask,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [7:0]    host_d,
   output logic          host_ack,
   output logic [7:0]    host_q,
   output logic [7:0]    abort_cnt,
   output logic [AW-1:0] bsram_addr,
   output logic [7:0]    bsram_d,
   output logic          bsram_ce_n,
   output logic          bsram_oe_n,
   output logic          bsram_we_n,
   input  logic [7:0]    bsram_q,
   output logic          dirty,
   input  logic          dirty_clr
);

   bsram_arb_state_t r_state;
   logic [AW-1:0]    r_haddr;
   logic [7:0]       r_hd;
   logic [1:0]       r_wait;
   logic             r_ack;
   logic [7:0]       r_hq;
   logic [7:0]       r_abort;

   logic w_host_bus;
   logic w_in_hrd;
   logic w_in_hwr;
   logic w_map_wr;

   assign w_in_hrd   = (r_state == ARB_HRD);
   assign w_in_hwr   = (r_state == ARB_HWR);
   // A read yields the pins back to the mapper in the very cycle map_ce_n drops.
   assign w_host_bus = w_in_hwr | (w_in_hrd & map_ce_n);

   assign bsram_addr = w_host_bus ? r_haddr    : map_addr;
   assign bsram_d    = w_host_bus ? r_hd       : map_d;
   assign bsram_ce_n = w_host_bus ? 1'b0       : map_ce_n;
   assign bsram_oe_n = w_host_bus ? ~w_in_hrd  : map_oe_n;
   assign bsram_we_n = w_host_bus ? ~w_in_hwr  : map_we_n;

   assign map_q     = bsram_q;
   assign host_ack  = r_ack;
   assign host_q    = r_hq;
   assign abort_cnt = r_abort;

   assign w_map_wr = ~w_host_bus & ~map_ce_n & ~map_we_n;

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
         r_haddr <= '0;
         r_hd    <= 8'h00;
         r_wait  <= 2'd0;
         r_ack   <= 1'b0;
         r_hq    <= 8'h00;
         r_abort <= 8'h00;
      end else begin
         r_ack <= 1'b0;
         unique case (r_state)
            ARB_IDLE: begin
               if (host_req && map_ce_n) begin
                  r_haddr <= host_addr & ram_mask;
                  r_hd    <= host_d;
                  if (host_we) begin
                     r_state <= ARB_HWR;
                  end else begin
                     r_state <= ARB_HRD;
                     r_wait  <= 2'(MEM_LAT);
                  end
               end
            end
            ARB_HWR: begin
               r_state <= ARB_HACK;
               r_ack   <= 1'b1;
            end
            ARB_HRD: begin
               if (!map_ce_n) begin
                  r_state <= ARB_IDLE;
                  if (r_abort != 8'hFF) begin
                     r_abort <= r_abort + 8'd1;
                  end
               end else if (r_wait == 2'd0) begin
                  r_hq    <= bsram_q;
                  r_state <= ARB_HACK;
                  r_ack   <= 1'b1;
               end else begin
                  r_wait <= r_wait - 2'd1;
               end
            end
            ARB_HACK: begin
               r_state <= ARB_IDLE;
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

`ifdef BSRAM_DIRTY_EN
   logic r_dirty;

   // Set beats clear so a mapper write coinciding with dirty_clr is never lost.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_dirty <= 1'b0;
      end else if (w_map_wr) begin
         r_dirty <= 1'b1;
      end else if (dirty_clr) begin
         r_dirty <= 1'b0;
      end
   end

   assign dirty = r_dirty;
`else
   logic w_unused_dirty;
   assign w_unused_dirty = dirty_clr & w_map_wr;
   assign dirty          = 1'b0;
`endif

endmodule

// File: tb/tb_bsram_host_arb.sv
// tb/tb_bsram_host_arb.sv - scoreboard bench for bsram_host_arb with a latency-accurate BSRAM model
module tb_bsram_host_arb;

   localparam int AW      = 20;
   localparam int MEM_LAT = 2;
`ifdef BSRAM_DIRTY_EN
   localparam bit DIRTY_ON = 1'b1;
`else
   localparam bit DIRTY_ON = 1'b0;
`endif

   logic          mclk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] map_addr = '0;
   logic [7:0]    map_d = 8'h00;
   logic          map_ce_n = 1'b1;
   logic          map_oe_n = 1'b1;
   logic          map_we_n = 1'b1;
   logic [7:0]    map_q;
   logic [AW-1:0] ram_mask = 20'h01FFF;
   logic          host_req = 1'b0;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [7:0]    host_d = 8'h00;
   logic          host_ack;
   logic [7:0]    host_q;
   logic [7:0]    abort_cnt;
   logic [AW-1:0] bsram_addr;
   logic [7:0]    bsram_d;
   logic          bsram_ce_n;
   logic          bsram_oe_n;
   logic          bsram_we_n;
   logic [7:0]    bsram_q;
   logic          dirty;
   logic          dirty_clr = 1'b0;

   bsram_host_arb #(.AW(AW), .MEM_LAT(MEM_LAT)) dut (
      .mclk(mclk), .rst_n(rst_n),
      .map_addr(map_addr), .map_d(map_d), .map_ce_n(map_ce_n), .map_oe_n(map_oe_n),
      .map_we_n(map_we_n), .map_q(map_q), .ram_mask(ram_mask),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_d(host_d),
      .host_ack(host_ack), .host_q(host_q), .abort_cnt(abort_cnt),
      .bsram_addr(bsram_addr), .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n),
      .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n), .bsram_q(bsram_q),
      .dirty(dirty), .dirty_clr(dirty_clr)
   );

   always #5 mclk = ~mclk;

   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   // BSRAM model: data is valid only after MEM_LAT cycles of continuous CE/OE low
   logic [7:0] mem [0:8191];
   int lo_cnt = 0;
   always @(posedge mclk) begin
      if (!bsram_ce_n && !bsram_oe_n) lo_cnt <= lo_cnt + 1;
      else lo_cnt <= 0;
      if (!bsram_ce_n && !bsram_we_n) mem[bsram_addr[12:0]] <= bsram_d;
   end
   assign bsram_q = (lo_cnt >= MEM_LAT) ? mem[bsram_addr[12:0]] : 8'hEE;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic [7:0] d;
      int         c;
      bit         rd;
   } exp_t;
   exp_t sb[$];

   // Host-driven strobe observation
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   logic [19:0] last_wa = '0;
   logic [7:0]  last_wd = 8'h00;

   always @(negedge mclk) begin
      if (rst_n && map_ce_n && !bsram_ce_n) begin
         if (!bsram_we_n) begin
            wr_cnt++;
            last_wa = bsram_addr;
            last_wd = bsram_d;
         end
         if (!bsram_oe_n) rd_cnt++;
      end
   end

   always @(negedge mclk) begin
      if (rst_n && host_ack) begin
         chk("ack_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_cycle", cyc, e.c);
            if (e.rd) chk("host_q", host_q, e.d);
         end
      end
   end

   int exp_abort = 0;

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // map_at < 0: no mapper activity; otherwise mapper strobes map_at cycles after req for map_hold cycles
   task automatic host_op(input logic we, input logic [19:0] a, input logic [7:0] d,
                          input logic [7:0] eq, input int map_at, input int map_hold, input logic map_wr);
      int   c0;
      int   lat;
      bit   seen;
      exp_t e;
      @(posedge mclk); #1;
      host_we = we; host_addr = a; host_d = d; host_req = 1'b1;
      c0  = cyc;
      lat = (we ? 2 : 4) + ((map_at >= 0) ? map_at + map_hold : 0);
      e.d = eq; e.c = c0 + lat; e.rd = !we;
      sb.push_back(e);
      if (map_at >= 0) begin
         repeat (map_at) begin @(posedge mclk); #1; end
         map_ce_n = 1'b0; map_we_n = !map_wr; map_oe_n = map_wr;
         map_addr = 20'h00777; map_d = 8'h99;
         #1;
         chk("map_owns_addr", bsram_addr, map_addr);
         chk("map_owns_ce", bsram_ce_n, 1'b0);
         chk("map_owns_oe", bsram_oe_n, map_oe_n);
         chk("map_owns_we", bsram_we_n, map_we_n);
         if (map_at > 0 && !we) exp_abort = sat_inc(exp_abort);
         repeat (map_hold) begin @(posedge mclk); #1; end
         map_ce_n = 1'b1; map_we_n = 1'b1; map_oe_n = 1'b1;
      end
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge mclk);
         if (host_ack) seen = 1'b1;
      end
      chk("ack_timeout", 32'(seen), 32'd1);
      host_req = 1'b0;
      chk("abort_cnt", abort_cnt, exp_abort);
   endtask

   task automatic map_write(input logic [19:0] a, input logic [7:0] d, input logic clr);
      @(posedge mclk); #1;
      map_addr = a; map_d = d; map_ce_n = 1'b0; map_we_n = 1'b0; dirty_clr = clr;
      @(posedge mclk); #1;
      map_ce_n = 1'b1; map_we_n = 1'b1; dirty_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   c0;
      bit   seen;
      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
      mem[13'h0010] = 8'hC3;

      // Reset: outputs idle, pins follow mapper
      map_addr = 20'h0ABCD; map_ce_n = 1'b0; map_oe_n = 1'b0;
      repeat (3) @(posedge mclk);
      #1;
      chk("rst_ack", host_ack, 1'b0);
      chk("rst_q", host_q, 8'h00);
      chk("rst_abort", abort_cnt, 8'h00);
      chk("rst_dirty", dirty, 1'b0);
      chk("rst_addr", bsram_addr, 20'h0ABCD);
      chk("rst_oe", bsram_oe_n, 1'b0);
      map_ce_n = 1'b1; map_oe_n = 1'b1; map_addr = '0;
      @(negedge mclk); rst_n = 1'b1;

      // Host write, mapper idle: one strobe, masked address
      wr_cnt = 0;
      host_op(1'b1, 20'h00123, 8'h5A, 8'h00, -1, 0, 1'b0);
      chk("wr_strobes", wr_cnt, 1);
      chk("wr_addr", last_wa, 20'h00123);
      chk("wr_data", last_wd, 8'h5A);
      chk("mem_123", mem[13'h0123], 8'h5A);
      chk("dirty_host_wr", dirty, 1'b0);

      // Masked write above ram_mask lands at the folded address
      wr_cnt = 0;
      host_op(1'b1, 20'hFE045, 8'h77, 8'h00, -1, 0, 1'b0);
      chk("mask_addr", last_wa, 20'h00045);
      chk("mem_045", mem[13'h0045], 8'h77);

      // Host read, MEM_LAT=2: oe low for 3 cycles
      rd_cnt = 0;
      host_op(1'b0, 20'h00010, 8'h00, 8'hC3, -1, 0, 1'b0);
      chk("rd_oe_cycles", rd_cnt, 3);
      host_op(1'b0, 20'h10045, 8'h00, 8'h77, -1, 0, 1'b0);

      // Read preempted in its 2nd HRD cycle, retried after mapper leaves
      host_op(1'b0, 20'h00010, 8'h00, 8'hC3, 2, 6, 1'b0);

      // Simultaneous host_req and mapper write: mapper wins, no abort
      host_op(1'b0, 20'h00123, 8'h00, 8'h5A, 0, 6, 1'b1);
      chk("map_wr_mem", mem[13'h0777], 8'h99);
      chk("map_q", map_q, bsram_q);

      // Dirty flag behaviour
      @(posedge mclk); #1; dirty_clr = 1'b1;
      @(posedge mclk); #1; dirty_clr = 1'b0;
      chk("dirty_cleared", dirty, 1'b0);
      map_write(20'h00100, 8'h11, 1'b0);
      chk("dirty_set", dirty, DIRTY_ON);
      map_write(20'h00101, 8'h22, 1'b1);
      chk("dirty_set_wins", dirty, DIRTY_ON);
      @(posedge mclk); #1; dirty_clr = 1'b1;
      @(posedge mclk); #1; dirty_clr = 1'b0;
      chk("dirty_clr_only", dirty, 1'b0);
      host_op(1'b1, 20'h00200, 8'h33, 8'h00, -1, 0, 1'b0);
      chk("dirty_host_only", dirty, 1'b0);

      // 300 forced aborts: counter saturates
      @(posedge mclk); #1;
      host_we = 1'b0; host_addr = 20'h00010; host_req = 1'b1;
      c0 = cyc;
      e.d = 8'hC3; e.c = c0 + 604; e.rd = 1'b1;
      sb.push_back(e);
      for (int i = 0; i < 300; i++) begin
         @(posedge mclk); #1;
         map_ce_n = 1'b0;
         @(posedge mclk); #1;
         map_ce_n = 1'b1;
         exp_abort = sat_inc(exp_abort);
         if (i >= 250) chk("abort_sat", abort_cnt, exp_abort);
      end
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge mclk);
         if (host_ack) seen = 1'b1;
      end
      chk("sat_ack_timeout", 32'(seen), 32'd1);
      host_req = 1'b0;
      chk("abort_final", abort_cnt, 8'd255);

      // Reset mid-read: pins return to mapper at once, no ack afterwards
      @(posedge mclk); #1;
      host_we = 1'b0; host_addr = 20'h00010; host_req = 1'b1;
      @(posedge mclk); #1;
      chk("hrd_driving", bsram_oe_n, 1'b0);
      #2; rst_n = 1'b0;
      #1;
      chk("rst_mid_oe", bsram_oe_n, 1'b1);
      chk("rst_mid_ce", bsram_ce_n, 1'b1);
      chk("rst_mid_abort", abort_cnt, 8'h00);
      chk("rst_mid_q", host_q, 8'h00);
      host_req = 1'b0;
      repeat (2) @(posedge mclk);
      @(negedge mclk); rst_n = 1'b1;
      repeat (10) @(posedge mclk);
      #1;
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
